// File: rtl/spi_ram_burst_if.sv
// spi_ram_burst_if: SPI pin bundle plus the RAM write strobe
interface spi_ram_burst_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic wr_strobe;
    modport master (output SS_n, MOSI, input MISO, wr_strobe);
    modport slave (input SS_n, MOSI, output MISO, wr_strobe);
endinterface

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: SPI slave decoding 2-bit command frames onto a single-port RAM with optional burst auto-increment
module spi_ram_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input logic            clk,
    input logic            rst,
    spi_ram_burst_if.slave bus
);
    localparam int SW  = DATA_WIDTH > ADDR_WIDTH ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CW  = $clog2(SW + 1);
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DLEN = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] ALEN = CW'(ADDR_WIDTH);
    localparam logic [AW1-1:0] DEPTH = AW1'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CMD, RX, TX, WAIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [SW-1:0]         rx_word;
    logic [CW-1:0]         rx_len;
    logic                  rx_last, tx_load, we;

    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] a);
        return a == LAST ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign rx_word = {sh_q[SW-2:0], bus.MOSI};
    assign rx_len  = cmd_q == 2'b01 ? DLEN : ALEN;
    assign rx_last = cnt_q == rx_len - CW'(1);
    assign tx_load = cnt_q == '0 || (AUTO_INC && cnt_q == DLEN);
    assign we      = !rst && !bus.SS_n && state_q == RX && cmd_q == 2'b01 && rx_last &&
                     {1'b0, wr_addr_q} < DEPTH;
    assign bus.MISO      = miso_q;
    assign bus.wr_strobe = we;

    // RAM write port and registered read port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr_q] <= rx_word[DATA_WIDTH-1:0];
        rd_q <= {1'b0, rd_addr_q} < DEPTH ? mem_q[rd_addr_q] : '0;
    end

    // Frame decoder next state: SS_n high always aborts back to IDLE
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        miso_d    = 1'b0;
        if (bus.SS_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_d   = {bus.MOSI, 1'b0};
                    state_d = CMD;
                end
                CMD: begin
                    cmd_d   = {cmd_q[1], bus.MOSI};
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = {cmd_q[1], bus.MOSI} == 2'b11 ? TX : RX;
                end
                RX: begin
                    sh_d  = rx_word;
                    cnt_d = cnt_q + CW'(1);
                    if (rx_last) begin
                        cnt_d   = '0;
                        state_d = WAIT;
                        if (cmd_q == 2'b00) wr_addr_d = rx_word[ADDR_WIDTH-1:0];
                        if (cmd_q == 2'b10) rd_addr_d = rx_word[ADDR_WIDTH-1:0];
                        if (cmd_q == 2'b01 && AUTO_INC) begin
                            wr_addr_d = inc(wr_addr_q);
                            state_d   = RX;
                        end
                    end
                end
                TX: begin
                    if (tx_load) begin
                        sh_d   = SW'(rd_q);
                        miso_d = rd_q[DATA_WIDTH-1];
                        cnt_d  = CW'(1);
                        if (AUTO_INC) rd_addr_d = inc(rd_addr_q);
                    end else if (cnt_q == DLEN) begin
                        state_d = WAIT;
                    end else begin
                        sh_d   = sh_q << 1;
                        miso_d = sh_q[DATA_WIDTH-2];
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            miso_q    <= miso_d;
        end
    end
endmodule
